// File: rtl/vending_machine_param.sv
// Parametrised multi-coin vending controller: collects coins, vends at PRICE, pays change as unit pulses.
// Latency: credit-reaching coin at edge k -> bottle in cycle k+1 -> first change_pulse in cycle k+2.
// No backpressure: coins that cannot be credited (busy, multi-coin, cancel, overflow) raise coin_reject.
module vending_machine_param #(
    parameter int PRICE       = 15,
    parameter int COIN_A_VAL  = 5,
    parameter int COIN_B_VAL  = 10,
    parameter int COIN_C_VAL  = 20,
    parameter int CHANGE_UNIT = 5,
    parameter int CW          = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          coin_a,
    input  logic          coin_b,
    input  logic          coin_c,
    input  logic          cancel,
    output logic          bottle,
    output logic          change_pulse,
    output logic          coin_reject,
    output logic          busy,
    output logic [CW-1:0] credit
);

    localparam int MAX_AB   = (COIN_A_VAL > COIN_B_VAL) ? COIN_A_VAL : COIN_B_VAL;
    localparam int MAX_COIN = (MAX_AB > COIN_C_VAL) ? MAX_AB : COIN_C_VAL;

    localparam logic [CW-1:0] PRICE_W = CW'(PRICE);
    localparam logic [CW-1:0] UNIT_W  = CW'(CHANGE_UNIT);
    localparam logic [CW-1:0] A_W     = CW'(COIN_A_VAL);
    localparam logic [CW-1:0] B_W     = CW'(COIN_B_VAL);
    localparam logic [CW-1:0] C_W     = CW'(COIN_C_VAL);

    // Reject parameter sets that would make change pulses or credit arithmetic meaningless.
    if (CHANGE_UNIT <= 0) begin : g_chk_unit
        $error("vending_machine_param: CHANGE_UNIT must be non-zero");
    end else begin : g_chk_mult
        if (PRICE <= 0 || (PRICE % CHANGE_UNIT) != 0) begin : g_chk_price
            $error("vending_machine_param: PRICE must be a non-zero multiple of CHANGE_UNIT");
        end
        if ((COIN_A_VAL % CHANGE_UNIT) != 0 || (COIN_B_VAL % CHANGE_UNIT) != 0 ||
            (COIN_C_VAL % CHANGE_UNIT) != 0) begin : g_chk_coin
            $error("vending_machine_param: coin values must be multiples of CHANGE_UNIT");
        end
    end
    if (((1 << CW) - 1) < (PRICE - CHANGE_UNIT + MAX_COIN)) begin : g_chk_cw
        $error("vending_machine_param: CW too narrow for PRICE and coin values");
    end

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_VEND    = 2'd1,
        ST_CHANGE  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] credit_nxt;
    logic          reject_nxt;
    logic [1:0]    coin_cnt;
    logic          any_coin;
    logic [CW-1:0] coin_val;
    logic [CW:0]   coin_sum;

    // State, credit and the registered reject pulse; reset discards any pending vend or change.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_COLLECT;
            credit      <= '0;
            coin_reject <= 1'b0;
        end else begin
            state       <= state_nxt;
            credit      <= credit_nxt;
            coin_reject <= reject_nxt;
        end
    end

    // Next-state and credit update; the extra sum bit catches credit overflow.
    always_comb begin
        state_nxt  = state;
        credit_nxt = credit;
        reject_nxt = 1'b0;
        coin_cnt   = {1'b0, coin_a} + {1'b0, coin_b} + {1'b0, coin_c};
        any_coin   = coin_a | coin_b | coin_c;
        coin_val   = coin_a ? A_W : (coin_b ? B_W : C_W);
        coin_sum   = {1'b0, credit} + {1'b0, coin_val};

        case (state)
            ST_COLLECT: begin
                if (cancel) begin
                    // Cancel wins over any coin arriving in the same cycle.
                    reject_nxt = any_coin;
                    if (credit != '0) begin
                        state_nxt = ST_CHANGE;
                    end
                end else if (coin_cnt > 2'd1) begin
                    reject_nxt = 1'b1;
                end else if (coin_cnt == 2'd1) begin
                    if (coin_sum[CW]) begin
                        reject_nxt = 1'b1;
                    end else begin
                        credit_nxt = coin_sum[CW-1:0];
                        if (coin_sum >= {1'b0, PRICE_W}) begin
                            state_nxt = ST_VEND;
                        end
                    end
                end
            end
            ST_VEND: begin
                reject_nxt = any_coin;
                credit_nxt = credit - PRICE_W;
                state_nxt  = (credit_nxt != '0) ? ST_CHANGE : ST_COLLECT;
            end
            ST_CHANGE: begin
                reject_nxt = any_coin;
                if (credit <= UNIT_W) begin
                    credit_nxt = '0;
                    state_nxt  = ST_COLLECT;
                end else begin
                    credit_nxt = credit - UNIT_W;
                end
            end
            default: begin
                state_nxt  = ST_COLLECT;
                credit_nxt = '0;
            end
        endcase
    end

    assign bottle       = (state == ST_VEND);
    assign change_pulse = (state == ST_CHANGE);
    assign busy         = (state == ST_VEND) || (state == ST_CHANGE);

endmodule

// File: doc/vending_machine_param.md
Name: vending_machine_param

Overview:
- Parametrised multi-coin vending controller. Accumulates credit from three coin inputs of configurable value and vends one item when credit reaches PRICE.
- Returns excess or cancelled credit as a serial train of one-cycle change pulses, one pulse per CHANGE_UNIT.
- Sits between the coin-acceptor front end and the dispenser/change-hopper drivers.

Parameters:
- PRICE, 15, item price in currency units; must be a non-zero multiple of CHANGE_UNIT.
- COIN_A_VAL, 5, value of coin_a; must be a multiple of CHANGE_UNIT.
- COIN_B_VAL, 10, value of coin_b; must be a multiple of CHANGE_UNIT.
- COIN_C_VAL, 20, value of coin_c; must be a multiple of CHANGE_UNIT.
- CHANGE_UNIT, 5, value returned per change_pulse; must be non-zero.
- CW, 8, credit register width; 2^CW-1 must be ≥ PRICE-CHANGE_UNIT+max coin value.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- coin_a  input  1  one-cycle pulse, coin A inserted
- coin_b  input  1  one-cycle pulse, coin B inserted
- coin_c  input  1  one-cycle pulse, coin C inserted
- cancel  input  1  one-cycle pulse, refund current credit
- bottle  output  1  high for exactly one cycle per vend
- change_pulse  output  1  high one cycle per CHANGE_UNIT returned
- coin_reject  output  1  registered, one-cycle pulse, coin not credited
- busy  output  1  high in VEND or CHANGE
- credit  output  CW  current credit register

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high on port reset, sampled at the rising edge.
- Reset values: state=COLLECT, credit=0, bottle=0, change_pulse=0, coin_reject=0, busy=0. Reset overrides all activity, including mid-VEND and mid-CHANGE; pending change is discarded.
- States:
  - COLLECT: accepting coins.
  - VEND: bottle=1, busy=1.
  - CHANGE: change_pulse=1, busy=1.
- bottle, change_pulse and busy are decoded from the state register only (Moore outputs).
- COLLECT, edge k, exactly one coin input high and cancel low:
  - credit <= credit+value.
  - If credit+value ≥ PRICE, state <= VEND; otherwise stay in COLLECT.
- COLLECT, edge k, two or more coin inputs high: coin_reject=1 for the cycle after edge k; credit unchanged.
- COLLECT, cancel high:
  - If credit>0, state <= CHANGE; else no effect.
  - Any coin in the same cycle is rejected (coin_reject=1); cancel has priority.
- VEND, next edge:
  - credit <= credit-PRICE.
  - state <= CHANGE if credit-PRICE>0, else COLLECT.
  - bottle is therefore high for exactly one cycle.
- CHANGE, each edge:
  - credit <= credit-CHANGE_UNIT.
  - If credit==CHANGE_UNIT, state <= COLLECT.
  - Number of change pulses = credit/CHANGE_UNIT on entry.
- Coins during VEND or CHANGE are rejected (coin_reject pulse); credit unchanged. cancel is ignored in VEND and CHANGE.
- Latency: credit-reaching coin sampled at edge k → bottle high in cycle k+1 → first change_pulse in cycle k+2.
- Back-to-back: a coin in the first COLLECT cycle after CHANGE is accepted normally.
- Arithmetic is unsigned CW-bit. A coin that would overflow credit is rejected; unreachable under legal parameters, but still implemented.
- Illegal parameter combinations (non-multiples, zero unit) are flagged at elaboration with $error.

Test Plan:
- Defaults used throughout: PRICE=15, coins 5/10/20, unit 5.
- Reset: assert reset 2 cycles → credit=0, bottle=0, change_pulse=0, busy=0, coin_reject=0.
- coin_a then coin_b on separate cycles → credit 5 then 15; bottle high for 1 cycle; credit 0; no change_pulse.
- coin_c → credit 20; bottle 1 cycle; credit 5; exactly 1 change_pulse; back to COLLECT with credit 0.
- coin_b then coin_c → credit 10, then 30; bottle 1 cycle; 3 consecutive change_pulse cycles; credit 15→10→5→0.
- coin_b then cancel → no bottle; 2 change_pulses; coin_a during CHANGE → coin_reject=1 and credit keeps decrementing.
- coin_a&coin_b in the same cycle → coin_reject, credit 0. Separately: coin_c, then reset asserted in the first CHANGE cycle → next cycle credit=0, change_pulse=0, busy=0.
